p_hit_core: RTL and testbench

//  Ray/plane hit-point stage of the ray tracer: per ray, t = dot(N1, v0-O1) / dot(N2, D1),

---
 rtl/p_hit_pkg.sv | 43 ++++
 rtl/p_hit_fifo.sv | 51 +++++
 rtl/p_hit_core.sv | 171 +++++++++++++++++
 tb/tb_p_hit_core.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/p_hit_pkg.sv
// rtl/p_hit_pkg.sv - shared types and fixed-point helpers for the ray/plane hit stage
package p_hit_pkg;

    typedef logic signed [31:0] fixed_t;
    typedef fixed_t [2:0] vec3_t;

    localparam int FIFO_DEPTH = 16;
    localparam int VEC_BITS   = 96;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DOT,
        S_DIV,
        S_MUL,
        S_WR
    } state_t;

    function automatic logic signed [63:0] fx_prod(input fixed_t a, input fixed_t b);
        logic signed [63:0] wa;
        logic signed [63:0] wb;
        wa = {{32{a[31]}}, a};
        wb = {{32{b[31]}}, b};
        return wa * wb;
    endfunction

    function automatic fixed_t fx_mul(input fixed_t a, input fixed_t b, input int q);
        logic signed [63:0] p;
        p = fx_prod(a, b) >>> q;
        return p[31:0];
    endfunction

    // Products are accumulated at full 64-bit precision before the single rescale.
    function automatic fixed_t fx_dot(input vec3_t a, input vec3_t b, input int q);
        logic signed [63:0] acc;
        acc = '0;
        for (int i = 0; i < 3; i++) begin
            acc = acc + fx_prod(a[i], b[i]);
        end
        acc = acc >>> q;
        return acc[31:0];
    endfunction

endpackage

// File: rtl/p_hit_fifo.sv
// rtl/p_hit_fifo.sv - first-word fall-through FIFO, head reads as zero while empty
module p_hit_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/p_hit_core.sv
// rtl/p_hit_core.sv - ray/plane hit point: t = dot(N1,v0-O1)/dot(N2,D1), P = O2 + t*D2
module p_hit_core
    import p_hit_pkg::*;
#(
    parameter int D_BITS = 35,
    parameter int Q_BITS = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  vec3_t      tri_normal_1,
    input  vec3_t      tri_normal_2,
    input  vec3_t      v0,
    input  vec3_t      origin_1,
    input  vec3_t      origin_2,
    input  vec3_t      dir_1,
    input  vec3_t      dir_2,
    input  logic [3:0] in_wr_en,
    output logic [3:0] in_full,
    output vec3_t      out,
    input  logic       out_rd_en,
    output logic       out_empty
);
    localparam int DW = 33 + D_BITS - 1;
    localparam int CW = $clog2(D_BITS + 1);

    state_t state;
    state_t state_next;

    vec3_t       in_data [4];
    vec3_t       in_head [4];
    logic [3:0]  in_empty;
    logic        in_pop;
    logic        out_push;
    logic        out_full;

    vec3_t          o1_r, o2_r, d1_r, d2_r;
    fixed_t         num_r, den_r;
    logic [DW-1:0]  rem_r, dsr_r;
    logic [31:0]    quo_r;
    logic           neg_r;
    logic [CW-1:0]  cnt_r;
    vec3_t          p_r;

    vec3_t          rel;
    fixed_t         num_next, den_next, t_val;
    logic [32:0]    num_mag, den_mag;
    vec3_t          p_next;

    assign in_data[0] = origin_1;
    assign in_data[1] = origin_2;
    assign in_data[2] = dir_1;
    assign in_data[3] = dir_2;

    for (genvar g = 0; g < 4; g++) begin : g_in
        p_hit_fifo #(.WIDTH(VEC_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clock   (clock),
            .reset   (reset),
            .wr_en   (in_wr_en[g]),
            .wr_data (in_data[g]),
            .full    (in_full[g]),
            .rd_en   (in_pop),
            .rd_data (in_head[g]),
            .empty   (in_empty[g])
        );
    end

    p_hit_fifo #(.WIDTH(VEC_BITS), .DEPTH(FIFO_DEPTH)) u_out_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (out_push),
        .wr_data (p_r),
        .full    (out_full),
        .rd_en   (out_rd_en),
        .rd_data (out),
        .empty   (out_empty)
    );

    always_comb begin
        rel = '0;
        for (int i = 0; i < 3; i++) begin
            rel[i] = v0[i] - o1_r[i];
        end
        num_next = fx_dot(tri_normal_1, rel, Q_BITS);
        den_next = fx_dot(tri_normal_2, d1_r, Q_BITS);
    end

    assign num_mag = num_r[31] ? (~{1'b1, num_r} + 33'd1) : {1'b0, num_r};
    assign den_mag = den_r[31] ? (~{1'b1, den_r} + 33'd1) : {1'b0, den_r};

    // Only the low 32 quotient bits survive into t, so negation is done modulo 2^32.
    assign t_val = neg_r ? fixed_t'(-quo_r) : fixed_t'(quo_r);

    always_comb begin
        p_next = '0;
        for (int i = 0; i < 3; i++) begin
            p_next[i] = o2_r[i] + fx_mul(t_val, d2_r[i], Q_BITS);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_pop     = 1'b0;
        out_push   = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_empty == 4'b0000 && !out_full) begin
                    in_pop     = 1'b1;
                    state_next = S_DOT;
                end
            end
            S_DOT: state_next = S_DIV;
            S_DIV: begin
                if (cnt_r == '0) begin
                    if (den_r == '0) state_next = S_MUL;
                end else if (cnt_r == CW'(D_BITS)) begin
                    state_next = S_MUL;
                end
            end
            S_MUL: state_next = S_WR;
            S_WR: begin
                out_push   = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Count 0 of DIV loads the operands; counts 1..D_BITS each retire one quotient bit.
    always_ff @(posedge clock) begin
        case (state)
            S_IDLE: begin
                if (in_pop) begin
                    o1_r <= in_head[0];
                    o2_r <= in_head[1];
                    d1_r <= in_head[2];
                    d2_r <= in_head[3];
                end
            end
            S_DOT: begin
                num_r <= num_next;
                den_r <= den_next;
                cnt_r <= '0;
            end
            S_DIV: begin
                cnt_r <= cnt_r + CW'(1);
                if (cnt_r == '0) begin
                    rem_r <= DW'(num_mag) << Q_BITS;
                    dsr_r <= DW'(den_mag) << (D_BITS - 1);
                    quo_r <= '0;
                    neg_r <= num_r[31] ^ den_r[31];
                end else begin
                    if (rem_r >= dsr_r) begin
                        rem_r <= rem_r - dsr_r;
                        quo_r <= {quo_r[30:0], 1'b1};
                    end else begin
                        quo_r <= {quo_r[30:0], 1'b0};
                    end
                    dsr_r <= dsr_r >> 1;
                end
            end
            S_MUL: p_r <= p_next;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_p_hit_core.sv
// tb/tb_p_hit_core.sv - randomized and directed bench for p_hit_core against an arithmetic model
module tb_p_hit_core;
    import p_hit_pkg::*;

    localparam int D_BITS = 35;
    localparam int Q_BITS = 16;
    localparam int U      = 32'h0001_0000;

    logic       clock = 1'b0;
    logic       reset;
    vec3_t      n1, n2, vv0, o1, o2, d1, d2;
    logic [3:0] in_wr_en;
    logic [3:0] in_full;
    vec3_t      out;
    logic       out_rd_en;
    logic       out_empty;

    int    checks = 0;
    int    errors = 0;
    vec3_t exp_q[$];
    bit    drain = 1'b0;
    bit    saw_full = 1'b0;

    always #5 clock = ~clock;

    p_hit_core #(.D_BITS(D_BITS), .Q_BITS(Q_BITS)) dut (
        .clock        (clock),
        .reset        (reset),
        .tri_normal_1 (n1),
        .tri_normal_2 (n2),
        .v0           (vv0),
        .origin_1     (o1),
        .origin_2     (o2),
        .dir_1        (d1),
        .dir_2        (d2),
        .in_wr_en     (in_wr_en),
        .in_full      (in_full),
        .out          (out),
        .out_rd_en    (out_rd_en),
        .out_empty    (out_empty)
    );

    function automatic vec3_t mk(int x, int y, int z);
        vec3_t v;
        v[0] = x;
        v[1] = y;
        v[2] = z;
        return v;
    endfunction

    function automatic int rnd_fx();
        return int'($urandom_range(0, 1048575)) - 524288;
    endfunction

    function automatic vec3_t rnd_vec();
        return mk(rnd_fx(), rnd_fx(), rnd_fx());
    endfunction

    // Plane hit evaluated with plain integer arithmetic; quotient magnitude saturates at D_BITS bits.
    function automatic vec3_t model(vec3_t a1, vec3_t b2, vec3_t c0,
                                    vec3_t r_o1, vec3_t r_o2, vec3_t r_d1, vec3_t r_d2);
        longint sn, sd, mn, md, q;
        int     num, den, t, diff;
        vec3_t  p;
        sn = 0;
        sd = 0;
        for (int i = 0; i < 3; i++) begin
            diff = int'(c0[i]) - int'(r_o1[i]);
            sn = sn + longint'(int'(a1[i])) * longint'(diff);
            sd = sd + longint'(int'(b2[i])) * longint'(int'(r_d1[i]));
        end
        num = int'(sn >>> Q_BITS);
        den = int'(sd >>> Q_BITS);
        if (den == 0) begin
            t = 0;
        end else begin
            mn = (num < 0) ? -longint'(num) : longint'(num);
            mn = mn << Q_BITS;
            md = (den < 0) ? -longint'(den) : longint'(den);
            q  = mn / md;
            if (q > (longint'(1) << D_BITS) - 1) q = (longint'(1) << D_BITS) - 1;
            if ((num < 0) != (den < 0)) q = -q;
            t = int'(q);
        end
        for (int i = 0; i < 3; i++) begin
            p[i] = int'(r_o2[i]) + int'((longint'(t) * longint'(int'(r_d2[i]))) >>> Q_BITS);
        end
        return p;
    endfunction

    task automatic check(string name, logic [95:0] act, logic [95:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic push_ray(vec3_t a, vec3_t b, vec3_t c, vec3_t d);
        @(posedge clock);
        #1;
        o1 = a;
        o2 = b;
        d1 = c;
        d2 = d;
        in_wr_en = 4'hF;
        if (in_full == 4'h0) exp_q.push_back(model(n1, n2, vv0, a, b, c, d));
        else saw_full = 1'b1;
    endtask

    task automatic end_push();
        @(posedge clock);
        #1;
        in_wr_en = 4'h0;
    endtask

    task automatic wait_result(output int n);
        n = 0;
        @(negedge clock);
        while (out_empty && n < 300) begin
            n++;
            @(negedge clock);
        end
    endtask

    task automatic wait_drained(string name, int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !out_empty) && n < limit) begin
            @(negedge clock);
            n++;
        end
        check(name, 96'(n < limit), 96'd1);
    endtask

    // Output checker: the FIFO head must always equal the oldest unconsumed model result.
    initial begin
        out_rd_en = 1'b0;
        forever begin
            @(negedge clock);
            if (reset && !out_empty) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected: actual %h required no result", out);
                end else if (out !== exp_q[0]) begin
                    errors++;
                    $display("FAIL out_vs_model: actual %h required %h", out, exp_q[0]);
                end
                if (drain && $urandom_range(0, 3) != 0) begin
                    out_rd_en = 1'b1;
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end else begin
                    out_rd_en = 1'b0;
                end
            end else begin
                out_rd_en = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1);
    end

    initial begin
        int    n;
        vec3_t r;
        reset = 1'b0;
        in_wr_en = 4'h0;
        n1 = '0; n2 = '0; vv0 = '0; o1 = '0; o2 = '0; d1 = '0; d2 = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_out_empty", 96'(out_empty), 96'd1);
        check("reset_in_full", 96'(in_full), 96'd0);
        check("reset_out", out, 96'd0);
        reset = 1'b1;
        drain = 1'b1;

        n1 = mk(0, 0, U);
        n2 = mk(0, 0, U);
        vv0 = mk(0, 0, 10 * U);
        r = model(n1, n2, vv0, mk(0, 0, 0), mk(0, 0, 0), mk(0, 0, U), mk(0, 0, U));
        check("model_basic", r, mk(0, 0, 32'h000A_0000));
        push_ray(mk(0, 0, 0), mk(0, 0, 0), mk(0, 0, U), mk(0, 0, U));
        end_push();
        wait_result(n);
        check("latency", 96'(n), 96'(D_BITS + 5));
        check("basic_out", out, mk(0, 0, 32'h000A_0000));
        wait_drained("basic_drain", 200);

        r = model(n1, n2, vv0, mk(U, 2 * U, 0), mk(U, 2 * U, 0), mk(0, 0, 32'h8000), mk(0, 0, 32'h8000));
        check("model_t20", r, mk(U, 2 * U, 32'h000A_0000));
        push_ray(mk(U, 2 * U, 0), mk(U, 2 * U, 0), mk(0, 0, 32'h8000), mk(0, 0, 32'h8000));
        end_push();
        wait_result(n);
        check("t20_out", out, mk(U, 2 * U, 32'h000A_0000));
        wait_drained("t20_drain", 200);

        vv0 = mk(0, 0, -4 * U);
        push_ray(mk(0, 0, 0), mk(0, 0, 0), mk(0, 0, U), mk(0, 0, U));
        end_push();
        wait_result(n);
        check("neg_t_out", out, mk(0, 0, 32'hFFFC_0000));
        wait_drained("neg_t_drain", 200);

        vv0 = mk(0, 0, 10 * U);
        push_ray(mk(0, 0, 0), mk(3 * U, -U, 5 * U), mk(U, 0, 0), mk(U, 0, 0));
        end_push();
        wait_result(n);
        check("den0_out", out, mk(3 * U, -U, 5 * U));
        wait_drained("den0_drain", 200);

        drain = 1'b0;
        saw_full = 1'b0;
        for (int i = 0; i < 20; i++) begin
            r = mk(rnd_fx(), rnd_fx(), 0);
            push_ray(r, r, mk(0, 0, int'($urandom_range(16384, 131072))), mk(0, 0, U));
        end
        end_push();
        check("in_full_seen", 96'(saw_full), 96'd1);
        check("accepted_rays", 96'(exp_q.size()), 96'd17);
        repeat (900) @(negedge clock);
        check("bp_out_empty", 96'(out_empty), 96'd0);
        check("bp_in_full", 96'(in_full), 96'd0);
        drain = 1'b1;
        wait_drained("bp_drain", 800);

        drain = 1'b0;
        for (int i = 0; i < 17; i++) begin
            push_ray(mk(0, 0, 0), mk(0, 0, 0), mk(0, 0, U), mk(0, 0, U));
        end
        end_push();
        check("fill_in_full", 96'(in_full), 96'hF);
        repeat (10) @(posedge clock);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("rst_out_empty", 96'(out_empty), 96'd1);
        check("rst_in_full", 96'(in_full), 96'd0);
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        drain = 1'b1;
        push_ray(mk(0, 0, 0), mk(0, 0, 0), mk(0, 0, U), mk(0, 0, U));
        end_push();
        wait_result(n);
        check("post_rst_out", out, mk(0, 0, 32'h000A_0000));
        wait_drained("post_rst_drain", 200);

        for (int s = 0; s < 4; s++) begin
            n1 = rnd_vec();
            n2 = rnd_vec();
            vv0 = rnd_vec();
            for (int i = 0; i < 8; i++) begin
                push_ray(rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());
                if ($urandom_range(0, 1) == 1) begin
                    end_push();
                    repeat ($urandom_range(0, 3)) @(posedge clock);
                end
            end
            end_push();
            wait_drained("rand_drain", 800);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
